// File: rtl/ifetch_npc_if.sv
// Instruction ROM read bus between the fetch stage and the ROM.
// One-cycle req pulse, rvalid returns the word some cycles later.
interface ifetch_npc_if #(
    parameter int ADDR_W = 14
);
    logic              irom_req;
    logic [ADDR_W-1:0] irom_addr;
    logic              irom_rvalid;
    logic [31:0]       irom_rdata;

    modport master (
        output irom_req,
        output irom_addr,
        input  irom_rvalid,
        input  irom_rdata
    );

    modport slave (
        input  irom_req,
        input  irom_addr,
        output irom_rvalid,
        output irom_rdata
    );
endinterface

// File: rtl/ifetch_npc.sv
// Fetch / next-PC stage: owns the PC, fetches from the instruction ROM,
// holds the instruction for decode and steps the PC on each commit.
module ifetch_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   npc_op,
    input  logic         br,
    input  logic [31:0]  imm,
    input  logic [31:0]  alu_c,
    input  logic         commit,
    ifetch_npc_if.master irom,
    output logic [31:0]  inst,
    output logic         inst_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc4,
    output logic         trap
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        iv_q, iv_d;
    logic        trap_q, trap_d;
    logic [31:0] npc;
    logic        req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            iv_q    <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            iv_q    <= iv_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        npc = pc_q + 32'd4;
        unique case (npc_op)
            2'b00: npc = pc_q + 32'd4;
            2'b01: npc = br ? pc_q + imm : pc_q + 32'd4;
            2'b10: npc = pc_q + imm;
            2'b11: npc = alu_c & ~32'h1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        iv_d    = iv_q;
        trap_d  = trap_q;
        req     = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                req     = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (irom.irom_rvalid) begin
                    inst_d  = irom.irom_rdata;
                    iv_d    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    iv_d = 1'b0;
                    // Word alignment only checks bit 1; bit 0 is always clear
                    if (npc[1]) begin
                        trap_d  = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign irom.irom_req  = req;
    assign irom.irom_addr = pc_q[ADDR_W+1:2];
    assign inst           = inst_q;
    assign inst_valid     = iv_q;
    assign pc             = pc_q;
    assign pc4            = pc_q + 32'd4;
    assign trap           = trap_q;
endmodule

// File: tb/tb_ifetch_npc.sv
// Directed bench for ifetch_npc with a latency-programmable ROM model.
// Checks reset, PC4 stepping, branches, JAL/JALR, wrap, trap and mid-run reset.
module tb_ifetch_npc;
    localparam int ADDR_W = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] alu_c = '0;
    logic        commit = 1'b0;
    logic [31:0] inst, pc, pc4;
    logic        inst_valid, trap;

    int vectors = 0;
    int errors = 0;
    int req_cnt = 0;
    int lat = 1;
    logic rv_force = 1'b0;

    ifetch_npc_if #(.ADDR_W(ADDR_W)) irom_bus ();

    ifetch_npc #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc_op     (npc_op),
        .br         (br),
        .imm        (imm),
        .alu_c      (alu_c),
        .commit     (commit),
        .irom       (irom_bus.master),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 | {18'd0, a};
    endfunction

    // ROM model: rvalid rises lat cycles after the req edge
    logic              pend;
    int                cnt;
    logic [ADDR_W-1:0] paddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= '0;
        end else begin
            if (pend) begin
                if (cnt == 0) pend <= 1'b0;
                else cnt <= cnt - 1;
            end
            if (irom_bus.irom_req) begin
                pend  <= 1'b1;
                cnt   <= lat - 1;
                paddr <= irom_bus.irom_addr;
            end
        end
    end

    assign irom_bus.irom_rvalid = (pend && cnt == 0) || rv_force;
    assign irom_bus.irom_rdata  = rom_word(paddr);

    always @(posedge clk) if (irom_bus.irom_req) req_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input string name);
        int n = 0;
        while (!inst_valid && n < 50) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            vectors++;
            errors++;
            $display("FAIL %s: inst_valid timeout after %0d cycles", name, n);
        end
    endtask

    task automatic do_commit(input logic [1:0] op, input logic b,
                             input logic [31:0] im, input logic [31:0] ac);
        npc_op = op;
        br     = b;
        imm    = im;
        alu_c  = ac;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        npc_op = 2'b00;
        br     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({pc, inst, inst_valid, irom_bus.irom_req, trap} !==
            {32'h0, 32'h13, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h inst=%h iv=%b req=%b trap=%b",
                     pc, inst, inst_valid, irom_bus.irom_req, trap);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (irom_bus.irom_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req: req=%b want 0", irom_bus.irom_req);
        end
        tick();
        vectors++;
        if (irom_bus.irom_req !== 1'b1 || irom_bus.irom_addr !== 14'd0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1/0",
                     irom_bus.irom_req, irom_bus.irom_addr);
        end
        tick();
        vectors++;
        if (irom_bus.irom_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle: req=%b iv=%b want 0/0",
                     irom_bus.irom_req, inst_valid);
        end
        tick();
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 32'hA000_0000) begin
            errors++;
            $display("FAIL first_inst: iv=%b inst=%h want 1/a0000000",
                     inst_valid, inst);
        end
    endtask

    task automatic test_pc4();
        logic [31:0] exp_pc = 32'h0;
        int          r0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (pc4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL pc4_out: got %h want %h", pc4, exp_pc + 32'd4);
            end
            r0 = req_cnt;
            do_commit(2'b00, 1'b0, 32'h0, 32'h0);
            exp_pc += 32'd4;
            wait_exec("pc4_step");
            vectors++;
            if (pc !== exp_pc || req_cnt - r0 !== 1 ||
                inst !== rom_word(exp_pc[ADDR_W+1:2])) begin
                errors++;
                $display("FAIL pc4_step: pc=%h reqs=%0d inst=%h want %h/1/%h",
                         pc, req_cnt - r0, inst, exp_pc,
                         rom_word(exp_pc[ADDR_W+1:2]));
            end
        end
    endtask

    task automatic test_branch();
        lat = 3;
        do_commit(2'b10, 1'b0, 32'h10, 32'h0);
        wait_exec("jal_to_20");
        vectors++;
        if (pc !== 32'h20) begin
            errors++;
            $display("FAIL jal_to_20: pc=%h want 00000020", pc);
        end
        do_commit(2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0);
        wait_exec("br_taken");
        vectors++;
        if (pc !== 32'h10 || inst !== rom_word(14'd4)) begin
            errors++;
            $display("FAIL br_taken: pc=%h inst=%h want 00000010", pc, inst);
        end
        do_commit(2'b10, 1'b0, 32'h10, 32'h0);
        wait_exec("jal_back");
        do_commit(2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0);
        wait_exec("br_not_taken");
        vectors++;
        if (pc !== 32'h24) begin
            errors++;
            $display("FAIL br_not_taken: pc=%h want 00000024", pc);
        end
        lat = 1;
    endtask

    task automatic test_jalr_wrap_trap();
        int r0;
        do_commit(2'b11, 1'b0, 32'h0, 32'h0000_0105);
        wait_exec("jalr_clear0");
        vectors++;
        if (pc !== 32'h104) begin
            errors++;
            $display("FAIL jalr_clear0: pc=%h want 00000104", pc);
        end
        do_commit(2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC);
        wait_exec("jalr_top");
        do_commit(2'b10, 1'b0, 32'h8, 32'h0);
        wait_exec("jal_wrap");
        vectors++;
        if (pc !== 32'h4 || trap !== 1'b0) begin
            errors++;
            $display("FAIL jal_wrap: pc=%h trap=%b want 00000004/0", pc, trap);
        end
        r0 = req_cnt;
        do_commit(2'b11, 1'b0, 32'h0, 32'h0000_0106);
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (trap !== 1'b1 || pc !== 32'h4 || inst_valid !== 1'b0 ||
            req_cnt != r0) begin
            errors++;
            $display("FAIL misalign_trap: trap=%b pc=%h iv=%b reqs=%0d want 1/4/0/0",
                     trap, pc, inst_valid, req_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        lat = 6;
        rst_n = 1'b1;
        commit = 1'b1;
        rv_force = 1'b1;
        tick();
        tick();
        commit = 1'b0;
        rv_force = 1'b0;
        vectors++;
        if (inst_valid !== 1'b0 || inst !== 32'h13 || pc !== 32'h0 ||
            trap !== 1'b0) begin
            errors++;
            $display("FAIL ignore_early: iv=%b inst=%h pc=%h trap=%b",
                     inst_valid, inst, pc, trap);
        end
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pc, inst, inst_valid, irom_bus.irom_req, trap} !==
            {32'h0, 32'h13, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_wait: pc=%h inst=%h iv=%b req=%b trap=%b",
                     pc, inst, inst_valid, irom_bus.irom_req, trap);
        end
        lat = 1;
        tick();
        rst_n = 1'b1;
        wait_exec("after_reset");
        do_commit(2'b00, 1'b0, 32'h0, 32'h0);
        wait_exec("exec_before_reset");
        vectors++;
        if (pc !== 32'h4 || inst !== rom_word(14'd1)) begin
            errors++;
            $display("FAIL exec_before_reset: pc=%h inst=%h want 4", pc, inst);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pc, inst, inst_valid, irom_bus.irom_req, trap} !==
            {32'h0, 32'h13, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_exec: pc=%h inst=%h iv=%b req=%b trap=%b",
                     pc, inst, inst_valid, irom_bus.irom_req, trap);
        end
    endtask

    initial begin
        test_reset();
        test_pc4();
        test_branch();
        test_jalr_wrap_trap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_npc.md
Name: ifetch_npc

Overview:
Instruction-fetch and next-PC stage sitting directly upstream of the decode/control unit in the single-cycle RV32I core. Owns the PC register, issues word reads to the instruction ROM through a req/rvalid handshake, and holds the fetched instruction stable for decode. On each commit from the core it loads the next PC selected by npc_op, the branch flag and the immediate/ALU result. A misaligned target halts the core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 14, word-address width of the instruction ROM; irom_addr = pc[ADDR_W+1:2].

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
npc_op  input  2  next-PC select from control: 00 PC4, 01 B, 10 JAL, 11 JALR.
br  input  1  branch-taken flag from ALU; used only when npc_op=01.
imm  input  32  sign-extended immediate from SEXT (B/J offset).
alu_c  input  32  ALU result; JALR target before bit-0 clear.
commit  input  1  core has finished executing the current inst; sampled only in S_EXEC.
irom_req  output  1  one-cycle read request pulse to instruction ROM.
irom_addr  output  ADDR_W  word address of the request.
irom_rvalid  input  1  ROM data valid; sampled only in S_WAIT.
irom_rdata  input  32  ROM read data.
inst  output  32  registered instruction to decode.
inst_valid  output  1  inst is valid for execution; gates rf_we/dram_we in the core.
pc  output  32  current PC.
pc4  output  32  pc + 4, combinational, for rf write-back select.
trap  output  1  sticky misaligned-target indication.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, irom_req=0, trap=0, state=S_BOOT. Reset asserted mid-operation aborts any outstanding fetch; the ROM shares rst_n, so no stale rvalid follows.
- States:
  S_BOOT: one cycle after reset release, then S_REQ.
  S_REQ: irom_req=1 for exactly this cycle, irom_addr=pc[ADDR_W+1:2]; next S_WAIT. rvalid in this cycle is ignored (ROM latency is at least 1 cycle).
  S_WAIT: hold. On irom_rvalid: inst<=irom_rdata and inst_valid<=1 in the same edge; next S_EXEC. No timeout; waits indefinitely.
  S_EXEC: inst_valid=1, inst and pc stable. commit=0 holds. On commit=1, compute npc. If npc[1]=0: pc<=npc, inst_valid<=0, go S_REQ. If npc[1]=1: pc unchanged, inst_valid<=0, trap<=1, go S_HALT.
  S_HALT: terminal until reset; no requests; trap stays 1.
- npc (32-bit, modulo 2^32, wraps silently):
  PC4: pc+4.
  B: br ? pc+imm : pc+4.
  JAL: pc+imm.
  JALR: alu_c & ~32'h1.
- commit or irom_rvalid outside their sampling state are ignored.
- Throughput: a fetch with ROM latency L costs 1 (REQ) + L (WAIT) + 1 (EXEC) cycles minimum per instruction.
- irom_addr is driven from pc in every state; only meaningful while irom_req=1.

Test Plan:
- Reset release with ROM latency 1 -> S_BOOT 1 cycle, irom_req pulses with irom_addr=0, and inst_valid rises 2 cycles after req with inst = ROM word 0.
- Four PC4 commits -> pc steps 0,4,8,12,16; exactly one irom_req per instruction; pc4 always pc+4.
- At pc=0x20, npc_op=01, imm=0xFFFF_FFF0: br=1 gives pc=0x10; repeat with br=0 gives pc=0x24.
- JALR with alu_c=0x0000_0105 -> pc=0x104; JALR with alu_c=0x0000_0106 -> trap=1, pc unchanged, irom_req stays 0 thereafter.
- JAL at pc=0xFFFF_FFFC with imm=8 -> pc wraps to 0x0000_0004; no trap.
- rst_n dropped in S_WAIT and in S_EXEC -> outputs immediately return to reset values; commit/rvalid pulses during S_BOOT/S_REQ are ignored.
